qk_score_engine: RTL
====================

Name: qk_score_engine

Overview:
- Per-head attention score stage; sits directly downstream of the Q/K projection output (seq_head_t rows) and upstream of the softmax row unit.
- Stores one head's Q and K matrices (SEQ x HEAD_DIM each) and computes S[i][j] = (sum_d Q[i][d]*K[j][d]) >>> SCALE_SHIFT, saturated to DATA_W.
- One multiply per cycle.
- Scores stream out row-major (j inner) on a valid/ready interface.

Parameters:
- SEQ, 16, tokens per sequence (rows/cols of S).
- HEAD_DIM, 8, dot-product length.
- DATA_W, 16, signed data width of Q, K and score.
- SCALE_SHIFT, 1, arithmetic right shift applied to the accumulator (approximates 1/sqrt(HEAD_DIM)).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_valid  in  1  write one Q or K row this cycle.
- ld_ready  out  1  high only in IDLE; loads with ld_ready low are dropped.
- ld_sel  in  1  0 = Q, 1 = K.
- ld_row  in  $clog2(SEQ)  row index.
- ld_data  in  HEAD_DIM*DATA_W  packed row; element d at bits [d*DATA_W +: DATA_W].
- start  in  1  begin full S computation; honoured only in IDLE.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the last score handshake.
- score_valid  out  1  score available.
- score_ready  in  1  consumer accepts.
- score_data  out  DATA_W  signed score.
- score_row  out  $clog2(SEQ)  i.
- score_col  out  $clog2(SEQ)  j.

Behaviour:
- Reset (async, rst_n low):
  - FSM to IDLE.
  - Counters i, j, d = 0; accumulator = 0.
  - busy = 0, done = 0, score_valid = 0, score_data/row/col = 0, ld_ready = 0 while in reset.
  - Q/K storage is not cleared.
- Reset mid-operation: the computation is abandoned; nothing resumes after reset release.
- FSM states:
  - IDLE: ld_ready = 1. start -> MAC with i = j = d = 0 and accumulator cleared.
  - MAC: acc += Q[i][d]*K[j][d] each cycle for d = 0..HEAD_DIM-1 (HEAD_DIM cycles). After d = HEAD_DIM-1 -> OUT.
  - OUT: score_valid = 1; data/row/col are registered and held stable until the handshake. On score_valid && score_ready: if (i, j) = (SEQ-1, SEQ-1) -> DONE; else advance j (wrap to 0, then i++), clear acc and d -> MAC.
  - DONE: done = 1 for one cycle -> IDLE.
- Same-cycle load and start in IDLE: the row write commits at that edge, and the MAC reads the updated row.
- Arithmetic:
  - Products are 2*DATA_W signed.
  - Accumulator ACC_W = 2*DATA_W + $clog2(HEAD_DIM) signed; it cannot overflow.
  - Score = saturate(acc >>> SCALE_SHIFT) to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; truncation, no rounding.
- Throughput: HEAD_DIM+1 cycles per score with score_ready held high; SEQ*SEQ*(HEAD_DIM+1) cycles from start to done, plus 1 for DONE.
- start while busy, and ld_valid while busy: ignored.
- score_ready without score_valid: no effect.

Optional Feature:
- Macro: QK_CAUSAL_MASK_EN.
- When defined, every score with j > i skips MAC: the FSM goes from the previous OUT directly to OUT with score_data = -2^(DATA_W-1).
- Masked scores are still emitted, so the handshake count stays SEQ*SEQ.
- When undefined, all scores are computed.

Decomposition:
- Shared package gains:
  - ACC_W constant and acc_t typedef;
  - score_t typedef (= data_t);
  - qk_state_t enum {IDLE, MAC, OUT, DONE};
  - a sat_shift function (acc_t -> data_t).
- One natural sub-module: qk_mac, the registered multiply-accumulate with clear/enable and ACC_W output.

Test Plan:
- Q[0] all 1, K[0] all 2, start, score_ready = 1 -> first score (0,0) = 8, valid 8 cycles after busy rises; done after 16*16*9 = 2304 OUT/MAC cycles.
- Q[3] all 32767, K[5] all 32767 -> score (3,5) = 32767 (saturated); Q[3] all -32768, K[5] all 32767 -> -32768.
- Q[1] = {1,-1,1,-1,...}, K[2] all 3 -> score (1,2) = 0; K[2] = {3,-3,...} -> 12.
- Hold score_ready low 5 cycles on the first OUT -> score_valid stays 1 with data/row/col unchanged; the next MAC starts only after the handshake.
- Assert rst_n low while in MAC at i = 2 -> busy, score_valid, done = 0 immediately; a later start recomputes from (0,0) with Q/K retained.
- With QK_CAUSAL_MASK_EN: score (0,1) = -32768, emitted 1 cycle after the (0,0) handshake; (1,0) computed normally; 256 handshakes total.

Source files
------------

// File: rtl/qk_score_engine_pkg.sv
// Shared types, sizing constants and the score saturation helper for the
// Q.K^T attention score engine.
package qk_score_engine_pkg;

  localparam int SEQ         = 16;
  localparam int HEAD_DIM    = 8;
  localparam int DATA_W      = 16;
  localparam int SCALE_SHIFT = 1;

  localparam int IDX_W = $clog2(SEQ);
  localparam int DIM_W = $clog2(HEAD_DIM);
  localparam int ACC_W = 2 * DATA_W + $clog2(HEAD_DIM);

  typedef logic signed [DATA_W-1:0]   data_t;
  typedef data_t                      score_t;
  typedef logic signed [2*DATA_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT,
    DONE
  } qk_state_t;

  localparam score_t SCORE_MAX = score_t'(2 ** (DATA_W - 1) - 1);
  localparam score_t SCORE_MIN = score_t'(-(2 ** (DATA_W - 1)));
  localparam acc_t   SAT_HI    = acc_t'(2 ** (DATA_W - 1) - 1);
  localparam acc_t   SAT_LO    = acc_t'(-(2 ** (DATA_W - 1)));

  // Arithmetic shift truncates toward minus infinity; no rounding is applied.
  function automatic score_t sat_shift(input acc_t acc);
    acc_t sh;
    sh = acc >>> SCALE_SHIFT;
    if (sh > SAT_HI) begin
      return SCORE_MAX;
    end
    if (sh < SAT_LO) begin
      return SCORE_MIN;
    end
    return score_t'(sh);
  endfunction

endpackage

// File: rtl/qk_score_engine_mac.sv
// qk_mac: registered signed multiply-accumulate with synchronous clear and
// enable; exposes the value being loaded so the caller can capture the final sum.
module qk_mac
  import qk_score_engine_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0] acc_next
);

  acc_t  acc_q;
  acc_t  acc_d;
  prod_t prod;

  always_comb begin
    prod  = prod_t'(data_t'(a)) * prod_t'(data_t'(b));
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + acc_t'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_next = acc_d;

endmodule

// File: rtl/qk_score_engine.sv
// Per-head attention score stage: stores Q and K, streams S = (Q.K^T) >>> SCALE_SHIFT.
// Optional causal masking (scores with j > i forced to the minimum) via QK_CAUSAL_MASK_EN.
module qk_score_engine
  import qk_score_engine_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic                       ld_sel,
  input  logic [IDX_W-1:0]           ld_row,
  input  logic [HEAD_DIM*DATA_W-1:0] ld_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       score_valid,
  input  logic                       score_ready,
  output logic [DATA_W-1:0]          score_data,
  output logic [IDX_W-1:0]           score_row,
  output logic [IDX_W-1:0]           score_col
);

  localparam logic [DIM_W-1:0] D_LAST   = DIM_W'(HEAD_DIM - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ - 1);

  data_t q_mem [SEQ][HEAD_DIM];
  data_t k_mem [SEQ][HEAD_DIM];

  qk_state_t        state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [DIM_W-1:0] d_q, d_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ld_ready_q, ld_ready_d;
  logic             score_valid_q, score_valid_d;
  score_t           score_data_q, score_data_d;
  logic [IDX_W-1:0] score_row_q, score_row_d;
  logic [IDX_W-1:0] score_col_q, score_col_d;

  logic             ld_fire;
  logic             mac_clear;
  logic             mac_en;
  logic [ACC_W-1:0] mac_acc_next;
  logic [IDX_W-1:0] nxt_i;
  logic [IDX_W-1:0] nxt_j;
  logic             last_col;

  assign ld_fire = ld_valid && ld_ready_q;

  // Storage is deliberately left out of reset so a reset keeps loaded Q/K.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      for (int e = 0; e < HEAD_DIM; e++) begin
        if (ld_sel) begin
          k_mem[ld_row][e] <= data_t'(ld_data[e*DATA_W +: DATA_W]);
        end else begin
          q_mem[ld_row][e] <= data_t'(ld_data[e*DATA_W +: DATA_W]);
        end
      end
    end
  end

  qk_mac u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (mac_clear),
    .en       (mac_en),
    .a        (q_mem[i_q][d_q]),
    .b        (k_mem[j_q][d_q]),
    .acc_next (mac_acc_next)
  );

  assign last_col = (j_q == IDX_LAST);
  assign nxt_j    = last_col ? '0 : j_q + IDX_W'(1);
  assign nxt_i    = last_col ? i_q + IDX_W'(1) : i_q;

  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    d_d           = d_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    score_valid_d = score_valid_q;
    score_data_d  = score_data_q;
    score_row_d   = score_row_q;
    score_col_d   = score_col_q;
    mac_clear     = 1'b0;
    mac_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = MAC;
          i_d       = '0;
          j_d       = '0;
          d_d       = '0;
          mac_clear = 1'b1;
          busy_d    = 1'b1;
        end
      end

      MAC: begin
        mac_en = 1'b1;
        d_d    = d_q + DIM_W'(1);
        // The final product is folded in here so the score registers with OUT.
        if (d_q == D_LAST) begin
          state_d       = OUT;
          d_d           = '0;
          score_valid_d = 1'b1;
          score_data_d  = sat_shift(acc_t'(mac_acc_next));
          score_row_d   = i_q;
          score_col_d   = j_q;
        end
      end

      OUT: begin
        if (score_ready) begin
          score_valid_d = 1'b0;
          if (last_col && (i_q == IDX_LAST)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d   = MAC;
            i_d       = nxt_i;
            j_d       = nxt_j;
            d_d       = '0;
            mac_clear = 1'b1;
`ifdef QK_CAUSAL_MASK_EN
            if (nxt_j > nxt_i) begin
              state_d       = OUT;
              score_valid_d = 1'b1;
              score_data_d  = SCORE_MIN;
              score_row_d   = nxt_i;
              score_col_d   = nxt_j;
            end
`endif
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ld_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      i_q           <= '0;
      j_q           <= '0;
      d_q           <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ld_ready_q    <= 1'b0;
      score_valid_q <= 1'b0;
      score_data_q  <= '0;
      score_row_q   <= '0;
      score_col_q   <= '0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      d_q           <= d_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ld_ready_q    <= ld_ready_d;
      score_valid_q <= score_valid_d;
      score_data_q  <= score_data_d;
      score_row_q   <= score_row_d;
      score_col_q   <= score_col_d;
    end
  end

  assign ld_ready    = ld_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign score_valid = score_valid_q;
  assign score_data  = score_data_q;
  assign score_row   = score_row_q;
  assign score_col   = score_col_q;

endmodule
